// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle multiply/divide for the execute stage; results held in hi/lo, busy stalls the pipe.
// Optional build macro MULDIV_SIGNED_EN enables sign handling for OP_MULT/OP_DIV.
module ex_muldiv_unit #(
  parameter logic [5:0] OP_MULT  = 6'b011000,
  parameter logic [5:0] OP_MULTU = 6'b011001,
  parameter logic [5:0] OP_DIV   = 6'b011010,
  parameter logic [5:0] OP_DIVU  = 6'b011011,
  parameter int         ITERS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      alu_op,
  input  logic [7:0][3:0] operand_a,
  input  logic [7:0][3:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] acc_hi, acc_lo, opb, a_raw;
  logic        is_div, dz;
  logic [31:0] a_w, b_w, a_mag, b_mag;
  logic        op_ok;

  assign a_w   = operand_a;
  assign b_w   = operand_b;
  assign op_ok = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                 (alu_op == OP_DIV)  || (alu_op == OP_DIVU);

  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign div_by_zero = done & dz;

`ifdef MULDIV_SIGNED_EN
  // Even opcodes (MULT/DIV) are the signed variants.
  logic sgn_op, neg_q, neg_r;
  assign sgn_op = ~alu_op[0];
  assign a_mag  = (sgn_op && a_w[31]) ? -a_w : a_w;
  assign b_mag  = (sgn_op && b_w[31]) ? -b_w : b_w;
`else
  assign a_mag  = a_w;
  assign b_mag  = b_w;
`endif

  // One shift-add (multiply) or restore step (divide) per RUN cycle.
  logic [32:0] sum, rem_s, diff;
  logic [31:0] nxt_hi, nxt_lo, res_hi, res_lo;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
    rem_s  = {acc_hi, acc_lo[31]};
    diff   = rem_s - {1'b0, opb};
    nxt_hi = sum[32:1];
    nxt_lo = {sum[0], acc_lo[31:1]};
    if (is_div) begin
      nxt_hi = diff[32] ? rem_s[31:0] : diff[31:0];
      nxt_lo = {acc_lo[30:0], ~diff[32]};
    end
  end

  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
`ifdef MULDIV_SIGNED_EN
    if (is_div) begin
      if (neg_q) res_lo = -nxt_lo;
      if (neg_r) res_hi = -nxt_hi;
    end else if (neg_q) begin
      {res_hi, res_lo} = -{nxt_hi, nxt_lo};
    end
`endif
    if (dz) begin
      res_hi = a_raw;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && op_ok) begin
            state  <= S_RUN;
            count  <= '0;
            is_div <= alu_op[1];
            dz     <= alu_op[1] && (b_w == 32'd0);
            a_raw  <= a_w;
            acc_hi <= '0;
            // multiply: multiplier shifts out of acc_lo; divide: dividend shifts out of acc_lo
            acc_lo <= alu_op[1] ? a_mag : b_mag;
            opb    <= alu_op[1] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= sgn_op && (a_w[31] ^ b_w[31]);
            neg_r  <= sgn_op && a_w[31];
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + 5'd1;
          if (count == 5'(ITERS - 1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (multiply, divide, div-by-zero, stalls, flush).
module tb_ex_muldiv_unit;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [5:0]      alu_op;
  logic [7:0][3:0] operand_a, operand_b;
  logic            busy, done, div_by_zero;
  logic [31:0]     hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive start at a negedge, let the next posedge sample it.
  task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge just after the sampling edge; counts edges (inclusive of that one).
  task automatic wait_done(output int edges, output int busy_cyc, output bit got, output bit dz);
    edges = 1; busy_cyc = 0; got = 0; dz = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        got = 1; dz = div_by_zero;
      end else begin
        @(posedge clk); edges++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cyc, output bit got, output bit dz);
    @(negedge clk);
    launch(op, a, b);
    wait_done(edges, busy_cyc, got, dz);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; start = 1'b1; alu_op = OP_MULTU;
    operand_a = 32'h5; operand_b = 32'h6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_multu;
    int e, bc; bit g, dz;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, e, bc, g, dz);
    n_checks++; if (!g || e != 33) begin n_fail++; $display("FAIL multu_latency got=%0d done=%b exp=33", e, g); end
    n_checks++; if (bc != 32) begin n_fail++; $display("FAIL multu_busy_cycles got=%0d exp=32", bc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
    n_checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", hi, lo); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL multu_dz got=%b exp=0", dz); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    n_checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL hilo_hold got=%h_%h exp=00000001_fffffffe", hi, lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, g, dz);
    n_checks++; if (!g || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin n_fail++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_divu;
    int e, bc; bit g, dz;
    run_op(OP_DIVU, 32'd100, 32'd7, e, bc, g, dz);
    n_checks++; if (!g || e != 33) begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", e); end
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL divu_100_7 got=lo %0d hi %0d exp=lo 14 hi 2", lo, hi); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divu_dz_clear got=%b exp=0", dz); end
    run_op(OP_DIVU, 32'd5, 32'd0, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin n_fail++; $display("FAIL divu_by_zero got=lo %h hi %h exp=lo ffffffff hi 5", lo, hi); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL divu_dz_flag got=%b exp=1", dz); end
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB || dz !== 1'b1) begin n_fail++; $display("FAIL div_by_zero got=lo %h hi %h dz %b exp=lo ffffffff hi fffffffb dz 1", lo, hi, dz); end
  endtask

  task automatic test_signed;
    int e, bc; bit g, dz;
`ifdef MULDIV_SIGNED_EN
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, e, bc, g, dz);
    n_checks++; if (!g || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m7_2 got=lo %h hi %h exp=lo fffffffd hi ffffffff", lo, hi); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin n_fail++; $display("FAIL div_7_m2 got=lo %h hi %h exp=lo fffffffd hi 1", lo, hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'h8000_0000 || hi !== 32'd0) begin n_fail++; $display("FAIL div_min_m1 got=lo %h hi %h exp=lo 80000000 hi 0", lo, hi); end
`else
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, e, bc, g, dz);
    n_checks++; if (!g || lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin n_fail++; $display("FAIL div_as_divu got=lo %h hi %h exp=lo 7ffffffc hi 1", lo, hi); end
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, e, bc, g, dz);
    n_checks++; if (!g || hi !== 32'h4 || lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_as_multu got=%h_%h exp=00000004_fffffff1", hi, lo); end
`endif
    n_checks++; if (e != 33) begin n_fail++; $display("FAIL signed_latency got=%0d exp=33", e); end
  endtask

  task automatic test_start_ignored;
    int e, bc; bit g, dz;
    @(negedge clk);
    launch(OP_MULTU, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    alu_op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand_a = 32'd9; operand_b = 32'd9;
    wait_done(e, bc, g, dz);
    n_checks++; if (!g || hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL start_while_busy got=%h_%h exp=00000000_0000002a", hi, lo); end
    n_checks++; if (e + 10 != 33) begin n_fail++; $display("FAIL start_while_busy_latency got=%0d exp=33", e + 10); end
  endtask

  task automatic test_invalid_op;
    @(negedge clk);
    launch(6'b000000, 32'd3, 32'd3);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL invalid_op_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL invalid_op_hold got=%b %h_%h exp=0 00000000_0000002a", done, hi, lo); end
  endtask

  task automatic test_back_to_back;
    int e, bc; bit g, dz;
    run_op(OP_MULTU, 32'd6, 32'd7, e, bc, g, dz);
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(e, bc, g, dz);
    n_checks++; if (!g || e != 33) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=33", e); end
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL b2b_result got=lo %0d hi %0d exp=lo 14 hi 2", lo, hi); end
  endtask

  task automatic test_flush;
    int dcount;
    @(negedge clk);
    launch(OP_MULTU, 32'd1000, 32'd1000);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    n_checks++; if (dcount != 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", dcount); end
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL flush_hold got=lo %0d hi %0d exp=lo 14 hi 2", lo, hi); end
    flush = 1'b1;
    launch(OP_MULTU, 32'd3, 32'd3);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_and_start got=%b exp=0", busy); end
    repeat (40) @(negedge clk);
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL flush_start_hold got=lo %0d hi %0d exp=lo 14 hi 2", lo, hi); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0;
    test_reset;
    test_multu;
    test_divu;
    test_signed;
    test_start_ignored;
    test_invalid_op;
    test_back_to_back;
    test_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
